// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through, runs req/ack bus
// transactions for loads/stores with lane alignment and load extension.
module mem_access #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      rd,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [63:0]     addr,
  input  logic [63:0]     wdata,
  input  logic [63:0]     alu_res,
  output logic            bus_req,
  output logic            bus_we,
  output logic [63:0]     bus_addr,
  output logic [63:0]     bus_wdata,
  output logic [7:0]      bus_wmask,
  input  logic            bus_ack,
  input  logic [63:0]     bus_rdata,
  output logic            stall_req,
  output logic            misalign,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd_out,
  output logic [63:0]     data_out
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  off;
  logic        is_mem, is_wr, misaligned_acc, go, kill, flush_q;
  logic [63:0] shifted, load_fmt, st_wdata, cap_data;
  logic [7:0]  st_wmask;

  // No bus timeout is implemented; the parameter is kept for interface compatibility.
  if (TIMEOUT != 0) begin : g_timeout_reserved
  end

  assign off    = addr[2:0];
  assign is_mem = in_valid & (is_load | is_store);
  assign is_wr  = is_store & ~is_load;
  assign go     = (state == IDLE) & is_mem & ~flush & ~misaligned_acc;
  assign kill   = flush_q | flush;

  always_comb begin
    misaligned_acc = 1'b0;
    case (funct3[1:0])
      2'b00:   misaligned_acc = 1'b0;
      2'b01:   misaligned_acc = addr[0];
      2'b10:   misaligned_acc = |addr[1:0];
      default: misaligned_acc = |addr[2:0];
    endcase
  end

  assign shifted  = bus_rdata >> {off, 3'b000};
  assign st_wdata = wdata << {off, 3'b000};

  always_comb begin
    load_fmt = shifted;
    st_wmask = 8'hFF;
    case (funct3[1:0])
      2'b00: begin
        load_fmt = {{56{~funct3[2] & shifted[7]}}, shifted[7:0]};
        st_wmask = 8'h01 << off;
      end
      2'b01: begin
        load_fmt = {{48{~funct3[2] & shifted[15]}}, shifted[15:0]};
        st_wmask = 8'h03 << off;
      end
      2'b10: begin
        load_fmt = {{32{~funct3[2] & shifted[31]}}, shifted[31:0]};
        st_wmask = 8'h0F << off;
      end
      default: begin
        load_fmt = shifted;
        st_wmask = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = REQ;
      REQ:     if (bus_ack) state_nx = kill ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall_req = 1'b0;
    misalign  = 1'b0;
    rd_out    = '0;
    data_out  = '0;
    pc_out    = rst ? '0 : pc;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            if (is_mem) begin
              if (misaligned_acc) misalign  = 1'b1;
              else                stall_req = 1'b1;
            end else begin
              rd_out   = rd;
              data_out = alu_res;
            end
          end
        end
        REQ:  stall_req = 1'b1;
        default: begin
          // Inputs are still held upstream here, so pc/rd belong to this instruction.
          if (!bus_we) begin
            rd_out   = flush ? '0 : rd;
            data_out = cap_data;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wmask <= '0;
      cap_data  <= '0;
      flush_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          flush_q <= 1'b0;
          if (go) begin
            bus_req   <= 1'b1;
            bus_we    <= is_wr;
            bus_addr  <= {addr[63:3], 3'b000};
            bus_wdata <= st_wdata;
            bus_wmask <= st_wmask;
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            flush_q <= 1'b0;
            if (!bus_we) cap_data <= load_fmt;
          end else if (flush) begin
            flush_q <= 1'b1;
          end
        end
        default: flush_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: scripted bus responder, transaction-level reference
// model, per-cycle compare process plus literal spot checks.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, is_load, is_store, bus_ack;
  logic [63:0] pc, addr, wdata, alu_res, bus_rdata;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        bus_req, bus_we, stall_req, misalign;
  logic [63:0] bus_addr, bus_wdata, pc_out, data_out;
  logic [7:0]  bus_wmask;
  logic [4:0]  rd_out;

  mem_access #(.XLEN(64), .TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .pc(pc), .rd(rd),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .wdata(wdata), .alu_res(alu_res), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_req(stall_req),
    .misalign(misalign), .pc_out(pc_out), .rd_out(rd_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  // Expected outputs for the current cycle
  logic        chk_en, e_stall, e_mis, e_bus_req, chk_data, chk_pc, chk_bus, e_we;
  logic [4:0]  e_rd;
  logic [63:0] e_data, e_pc, e_addr, e_wdata;
  logic [7:0]  e_wmask;

  // Observations for literal spot checks
  int          stall_cnt = 0, mis_cnt = 0, bus_req_cnt = 0, rd_nz_cnt = 0;
  logic [63:0] last_data, last_pc, snap_addr, snap_wdata;
  logic [4:0]  last_rd;
  logic [7:0]  snap_wmask;
  logic        snap_we, last_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_req", 64'(stall_req), 64'(e_stall));
      check("misalign", 64'(misalign), 64'(e_mis));
      check("rd_out", 64'(rd_out), 64'(e_rd));
      check("bus_req", 64'(bus_req), 64'(e_bus_req));
      if (chk_data) check("data_out", data_out, e_data);
      if (chk_pc) check("pc_out", pc_out, e_pc);
      if (chk_bus) begin
        check("bus_we", 64'(bus_we), 64'(e_we));
        check("bus_addr", bus_addr, e_addr);
        if (e_we) begin
          check("bus_wdata", bus_wdata, e_wdata);
          check("bus_wmask", 64'(bus_wmask), 64'(e_wmask));
        end
      end
    end
    if (stall_req) stall_cnt++;
    if (misalign) mis_cnt++;
    if (bus_req) begin
      bus_req_cnt++;
      snap_addr  = bus_addr;
      snap_wdata = bus_wdata;
      snap_wmask = bus_wmask;
      snap_we    = bus_we;
    end
    if (rd_out != 5'd0) rd_nz_cnt++;
    last_data  = data_out;
    last_pc    = pc_out;
    last_rd    = rd_out;
    last_stall = stall_req;
  end

  // ---------------- reference model ----------------
  function automatic int unsigned m_size(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic bit m_misaligned(input logic [63:0] a, input logic [2:0] f);
    return (int'(a[2:0]) % m_size(f)) != 0;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [63:0] a,
                                         input logic [2:0] f);
    int unsigned n = 8 * m_size(f);
    logic [63:0] v = rdata >> (8 * int'(a[2:0]));
    logic [63:0] mask;
    if (n < 64) begin
      mask = (64'd1 << n) - 64'd1;
      v = v & mask;
      if (f < 3'd4 && v[n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [7:0] m_wmask(input logic [63:0] a, input logic [2:0] f);
    logic [15:0] m = ((16'd1 << m_size(f)) - 16'd1) << int'(a[2:0]);
    return m[7:0];
  endfunction

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_stall = 0; e_mis = 0; e_rd = '0; e_data = '0; chk_data = 1;
    chk_pc = 0; chk_bus = 0; e_bus_req = 0; e_we = 0;
  endtask

  task automatic drive_idle();
    in_valid = 0; flush = 0; is_load = 0; is_store = 0; bus_ack = 0;
    set_idle_exp();
    step();
  endtask

  task automatic run_alu(input logic [63:0] a_pc, input logic [4:0] a_rd,
                         input logic [63:0] a_res, input bit a_flush);
    in_valid = 1; is_load = 0; is_store = 0; flush = a_flush; bus_ack = 0;
    pc = a_pc; rd = a_rd; alu_res = a_res; funct3 = 3'($urandom); addr = {$urandom, $urandom};
    set_idle_exp();
    e_rd = a_flush ? 5'd0 : a_rd;
    e_data = a_flush ? 64'd0 : a_res;
    chk_pc = !a_flush; e_pc = a_pc;
    step();
    flush = 0;
  endtask

  task automatic run_mem(input logic [63:0] a_pc, input logic [4:0] a_rd, input bit ld,
                         input bit st, input logic [2:0] f3, input logic [63:0] a_addr,
                         input logic [63:0] a_wdata, input logic [63:0] rdata,
                         input int unsigned delay, input int flush_at, input bit flush_done,
                         input bit flush_issue);
    bit wr = st && !ld;
    in_valid = 1; is_load = ld; is_store = st; funct3 = f3; addr = a_addr;
    wdata = a_wdata; pc = a_pc; rd = a_rd; alu_res = {$urandom, $urandom};
    bus_ack = 0; flush = flush_issue;
    set_idle_exp();
    if (flush_issue) begin
      step(); flush = 0; return;
    end
    if (m_misaligned(a_addr, f3)) begin
      e_mis = 1; step(); return;
    end
    e_stall = 1;
    step();
    for (int unsigned c = 1; c <= delay + 1; c++) begin
      bus_ack = (c == delay + 1);
      bus_rdata = bus_ack ? rdata : {$urandom, $urandom};
      flush = (flush_at == int'(c));
      e_stall = 1; e_bus_req = 1; chk_bus = 1; e_we = wr;
      e_addr = a_addr & ~64'd7;
      e_wdata = a_wdata << (8 * int'(a_addr[2:0]));
      e_wmask = m_wmask(a_addr, f3);
      step();
    end
    bus_ack = 0; flush = 0; bus_rdata = {$urandom, $urandom};
    if (flush_at >= 1) return;
    flush = flush_done;
    set_idle_exp();
    chk_pc = 1; e_pc = a_pc;
    if (!wr) begin
      e_rd = flush_done ? 5'd0 : a_rd;
      e_data = m_load(rdata, a_addr, f3);
      chk_data = !flush_done;
    end
    step();
    flush = 0;
  endtask

  initial begin
    logic [63:0] base;
    logic [2:0]  f3;
    int unsigned off, sz, dly, kind;
    int          fat;
    bit          ld, st, fiss;

    rst = 1; flush = 0; in_valid = 1; pc = 64'h1000; rd = 5'd5; is_load = 0; is_store = 0;
    funct3 = 0; addr = 0; wdata = 0; alu_res = 64'hDEAD; bus_ack = 0; bus_rdata = 0;
    chk_en = 0;
    set_idle_exp();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_misalign", 64'(misalign), 64'd0);
    check("rst_rd_out", 64'(rd_out), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_pc_out", pc_out, 64'd0);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_bus_wmask", 64'(bus_wmask), 64'd0);
    rst = 0;
    chk_en = 1;

    // ALU pass-through
    bus_req_cnt = 0;
    run_alu(64'h1000, 5'd5, 64'hDEAD, 0);
    check("alu_pc", last_pc, 64'h1000);
    check("alu_rd", 64'(last_rd), 64'd5);
    check("alu_data", last_data, 64'hDEAD);
    check("alu_stall", 64'(last_stall), 64'd0);
    check("alu_no_bus_req", 64'(bus_req_cnt), 64'd0);

    // LB sign extension, ack in first REQ cycle
    stall_cnt = 0;
    run_mem(64'h1004, 5'd7, 1, 0, 3'b000, 64'h2003, 64'd0, 64'h0000_0000_8000_0000, 0, -1, 0, 0);
    check("lb_data", last_data, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_rd", 64'(last_rd), 64'd7);
    check("lb_bus_addr", snap_addr, 64'h2000);
    check("lb_stall_cycles", 64'(stall_cnt), 64'd2);

    // SW byte lanes
    run_mem(64'h1008, 5'd9, 0, 1, 3'b010, 64'h3004, 64'h1122_3344, 64'd0, 1, -1, 0, 0);
    check("sw_we", 64'(snap_we), 64'd1);
    check("sw_wmask", 64'(snap_wmask), 64'hF0);
    check("sw_wdata", snap_wdata, 64'h1122_3344_0000_0000);
    check("sw_rd", 64'(last_rd), 64'd0);

    // LD with 4 wait cycles
    stall_cnt = 0;
    run_mem(64'h100C, 5'd11, 1, 0, 3'b011, 64'h5008, 64'd0, 64'h0123_4567_89AB_CDEF, 4, -1, 0, 0);
    check("ld_wait_data", last_data, 64'h0123_4567_89AB_CDEF);
    check("ld_wait_stall_cycles", 64'(stall_cnt), 64'd6);

    // Misaligned LW
    mis_cnt = 0; bus_req_cnt = 0; rd_nz_cnt = 0;
    run_mem(64'h1010, 5'd12, 1, 0, 3'b010, 64'h4002, 64'd0, 64'd0, 0, -1, 0, 0);
    drive_idle();
    check("mis_pulses", 64'(mis_cnt), 64'd1);
    check("mis_no_bus_req", 64'(bus_req_cnt), 64'd0);
    check("mis_rd", 64'(rd_nz_cnt), 64'd0);

    // Flush in REQ, ack two cycles later
    bus_req_cnt = 0; rd_nz_cnt = 0;
    run_mem(64'h1014, 5'd13, 1, 0, 3'b011, 64'h6000, 64'd0, 64'hAAAA_5555_AAAA_5555, 2, 1, 0, 0);
    drive_idle();
    drive_idle();
    check("flush_req_cycles", 64'(bus_req_cnt), 64'd3);
    check("flush_rd", 64'(rd_nz_cnt), 64'd0);

    // Reset asserted mid-REQ
    in_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b011; addr = 64'h7000;
    pc = 64'h1018; rd = 5'd3; flush = 0; bus_ack = 0;
    set_idle_exp(); e_stall = 1;
    step();
    e_bus_req = 1; chk_bus = 1; e_we = 0; e_addr = 64'h7000;
    step();
    chk_en = 0;
    #2 rst = 1;
    #1;
    check("rstreq_bus_req", 64'(bus_req), 64'd0);
    check("rstreq_stall", 64'(stall_req), 64'd0);
    check("rstreq_rd", 64'(rd_out), 64'd0);
    @(posedge clk);
    #1;
    rst = 0; in_valid = 0;
    set_idle_exp();
    chk_en = 1;
    step();
    run_mem(64'h101C, 5'd4, 1, 0, 3'b101, 64'h7006, 64'd0, 64'hBEEF_0000_0000_0000, 0, -1, 0, 0);
    check("post_rst_lhu", last_data, 64'h0000_0000_0000_BEEF);

    // Randomized mix
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        run_alu({$urandom, $urandom}, 5'($urandom), {$urandom, $urandom}, $urandom_range(0, 7) == 0);
      end else if (kind == 3) begin
        drive_idle();
      end else begin
        f3 = 3'($urandom);
        sz = m_size(f3);
        base = {$urandom, $urandom};
        off = $urandom_range(0, 7);
        if ($urandom_range(0, 9) < 7) off = (off / sz) * sz;
        ld = $urandom_range(0, 1);
        st = !ld || ($urandom_range(0, 9) == 0);
        dly = $urandom_range(0, 4);
        fat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, dly + 1)) : -1;
        fiss = ($urandom_range(0, 15) == 0) && !m_misaligned({base[63:3], 3'(off)}, f3);
        run_mem({$urandom, $urandom}, 5'($urandom), ld, st, f3, {base[63:3], 3'(off)},
                {$urandom, $urandom}, {$urandom, $urandom}, dly, fat,
                $urandom_range(0, 7) == 0, fiss);
      end
    end
    drive_idle();
    chk_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage. Sits between the EX/MA pipeline register and the MA/WB pipeline register.
- Non-memory instructions pass through combinationally with zero added latency.
- Loads and stores run a req/ack transaction on the 64-bit data bus, with byte-lane alignment, store masking and load sign/zero extension.
- Holds the pipeline via stall_req until the result is ready. Its pc_out/rd_out/data_out feed the MA/WB register directly.

Parameters:
XLEN, 64, width of pc and address
TIMEOUT, 0, reserved; 0 means no bus timeout (no timeout logic is built)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
flush  in  1  kill the instruction currently in this stage
in_valid  in  1  EX/MA slot holds a valid instruction
pc  in  XLEN  instruction pc
rd  in  5  destination register; 0 = no writeback
is_load  in  1  instruction is a load
is_store  in  1  instruction is a store
funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
addr  in  64  effective address
wdata  in  64  store data, right-justified
alu_res  in  64  result for non-memory instructions
bus_req  out  1  data bus request
bus_we  out  1  1 = write
bus_addr  out  64  doubleword-aligned address {addr[63:3],3'b0}
bus_wdata  out  64  lane-shifted store data
bus_wmask  out  8  byte enables
bus_ack  in  1  transaction complete; bus_rdata valid this cycle
bus_rdata  in  64  read data
stall_req  out  1  hold upstream stages and the MA/WB register
misalign  out  1  one-cycle pulse: misaligned access detected
pc_out  out  XLEN  to MA/WB register
rd_out  out  5  to MA/WB register
data_out  out  64  to MA/WB register

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset (async, rst=1):
  - State goes to IDLE.
  - All registered bus outputs, including bus_req and the captured-data register, go to 0.
  - Outputs while in reset: stall_req=0, misalign=0, rd_out=0, data_out=0, pc_out=0.
  - Reset during REQ abandons the transaction without waiting for ack.
- Misalignment check:
  - H: addr[0]!=0. W: addr[1:0]!=0. D: addr[2:0]!=0. B is never misaligned.
  - On a misaligned access in IDLE: misalign=1, rd_out=0, data_out=0, no bus request, stall_req=0, remain in IDLE.
- IDLE:
  - Not in_valid, or flush=1: rd_out=0, data_out=0, stall_req=0.
  - Valid, non-memory instruction: pc_out=pc, rd_out=rd, data_out=alu_res, stall_req=0.
  - Valid, aligned load or store: stall_req=1 (combinational, same cycle). Register bus_addr, bus_we (=is_store), bus_wdata and bus_wmask. Set bus_req=1 from the next cycle. Next state REQ. rd_out=0 this cycle.
- REQ:
  - bus_req and all bus fields stay constant until bus_ack. stall_req=1 and rd_out=0.
  - On bus_ack: deassert bus_req at the next edge. On a load, capture the formatted rdata. Next state DONE.
  - flush during REQ is latched. The transaction still completes (it cannot be aborted). On ack, go to IDLE instead of DONE; the result is dropped.
- DONE (exactly one cycle):
  - stall_req=0 and pc_out=pc.
  - Load: rd_out=rd, data_out=captured data.
  - Store: rd_out=0, data_out=0.
  - flush=1 forces rd_out=0.
  - Next state always IDLE. Upstream advances on this edge, so the same instruction is never reissued.
- Store formatting, with off = addr[2:0]:
  - bus_wdata = wdata << (8*off).
  - bus_wmask: B = 0x01<<off, H = 0x03<<off, W = 0x0F<<off, D = 0xFF.
- Load formatting: shifted = bus_rdata >> (8*off), then take the low 8/16/32/64 bits. Sign-extend for B/H/W; zero-extend for BU/HU/WU.
- funct3=111: treated as D.
- is_load and is_store both set: treated as load.
- Minimum load/store latency is 3 cycles (IDLE, REQ with same-cycle ack, DONE). Each extra wait cycle on the bus adds one cycle.

Test Plan:
- ALU pass-through: in_valid, pc=0x1000, rd=5, alu_res=0xDEAD -> same cycle pc_out=0x1000, rd_out=5, data_out=0xDEAD, stall_req=0, bus_req never asserted.
- LB sign-extend: addr=0x2003, funct3=000, ack one cycle after req, bus_rdata=0x0000_0000_8000_0000 -> bus_addr=0x2000; in DONE data_out=0xFFFF_FFFF_FFFF_FF80, rd_out=rd; stall_req high exactly 2 cycles.
- SW lanes: addr=0x3004, wdata=0x1122_3344, funct3=010 -> bus_we=1, bus_wmask=0xF0, bus_wdata=0x1122_3344_0000_0000; in DONE rd_out=0.
- Bus wait states: LD with ack delayed 4 cycles -> bus_req/bus_addr stable for all 4 cycles, stall_req held; data_out=bus_rdata in DONE.
- Misaligned LW at addr=0x4002 -> misalign=1 for one cycle, no bus_req, rd_out=0, stall_req=0.
- Flush in REQ, then ack 2 cycles later -> transaction completes, no DONE cycle, rd_out stays 0. Separately, rst asserted mid-REQ -> bus_req=0 and state IDLE immediately.
